// File: rtl/cc_punct_enc_if.sv
// Byte-in / bit-out stream bundle for the convolutional encoder + puncturer.
// The master drives bytes in and accepts coded bits; the slave is the encoder.
interface cc_punct_enc_if;
   logic [1:0] rate;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_sop;
   logic       in_eop;
   logic       in_ready;
   logic       out_bit;
   logic       out_valid;
   logic       out_sop;
   logic       out_eop;
   logic       out_ready;

   modport master (
      output rate, in_data, in_valid, in_sop, in_eop, out_ready,
      input  in_ready, out_bit, out_valid, out_sop, out_eop
   );

   modport slave (
      input  rate, in_data, in_valid, in_sop, in_eop, out_ready,
      output in_ready, out_bit, out_valid, out_sop, out_eop
   );
endinterface

// File: rtl/cc_punct_enc.sv
// K=7 rate-1/2 convolutional encoder with 1/2, 2/3, 3/4, 5/6 puncturing.
// Bytes enter MSB first; one coded bit leaves per accepted output beat.
module cc_punct_enc #(
   parameter logic [6:0] G1 = 7'o171,
   parameter logic [6:0] G2 = 7'o133
) (
   input  logic          clk,
   input  logic          reset_n,
   cc_punct_enc_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EMIT_X, EMIT_Y} state_t;

   state_t     r_state;
   logic [7:0] r_byte;
   logic [2:0] r_idx;
   logic [5:0] r_sr;   // r_sr[5] = sr1 (newest) ... r_sr[0] = sr6 (oldest)
   logic [2:0] r_p;
   logic [1:0] r_rate;
   logic       r_eop_byte;
   logic       r_out_bit;
   logic       r_out_valid;
   logic       r_out_sop;
   logic       r_out_eop;

   function automatic logic [2:0] period(input logic [1:0] rt);
      case (rt)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         2'b10:   return 3'd3;
         default: return 3'd5;
      endcase
   endfunction

   function automatic logic mask_x(input logic [1:0] rt, input logic [2:0] p);
      case (rt)
         2'b00:   return 1'b1;
         2'b01:   return p == 3'd0;
         2'b10:   return p != 3'd1;
         default: return !p[0];
      endcase
   endfunction

   function automatic logic mask_y(input logic [1:0] rt, input logic [2:0] p);
      case (rt)
         2'b00, 2'b01: return 1'b1;
         2'b10:        return p != 3'd2;
         default:      return (p != 3'd2) && (p != 3'd4);
      endcase
   endfunction

   function automatic logic code_bit(input logic u, input logic [5:0] sr, input logic [6:0] g);
      return ^({u, sr} & g);
   endfunction

   logic       w_u_cur;
   logic       w_out_acc;
   logic       w_adv;
   logic       w_in_ready;
   logic       w_load;
   logic [5:0] w_sr_adv;
   logic [2:0] w_p_adv;
   logic [5:0] w_sr_base;
   logic [2:0] w_p_base;
   logic       w_st_u;
   logic [5:0] w_st_sr;
   logic [2:0] w_st_p;
   logic [1:0] w_st_rate;
   logic [2:0] w_st_idx;
   logic       w_st_eopb;
   logic       w_st_x;
   logic       w_st_bit;
   logic       w_st_eop;

   assign w_u_cur    = r_byte[r_idx];
   assign w_out_acc  = r_out_valid & bus.out_ready;
   assign w_adv      = w_out_acc & ((r_state == EMIT_Y) |
                                    ((r_state == EMIT_X) & !mask_y(r_rate, r_p)));
   assign w_in_ready = (r_state == IDLE) | (w_adv & (r_idx == 3'd0));
   assign w_load     = bus.in_valid & w_in_ready;
   assign w_sr_adv   = {w_u_cur, r_sr[5:1]};
   assign w_p_adv    = (r_p == 3'(period(r_rate) - 3'd1)) ? 3'd0 : 3'(r_p + 3'd1);

   // Context of the next bit to emit: either a freshly loaded byte (whose sr/p
   // already reflect the byte just finishing) or the next bit of the held byte.
   always_comb begin
      w_sr_base = (r_state == IDLE) ? r_sr : w_sr_adv;
      w_p_base  = (r_state == IDLE) ? r_p  : w_p_adv;
      w_st_u    = r_byte[3'(r_idx - 3'd1)];
      w_st_sr   = w_sr_adv;
      w_st_p    = w_p_adv;
      w_st_rate = r_rate;
      w_st_idx  = 3'(r_idx - 3'd1);
      w_st_eopb = r_eop_byte;
      if (w_load) begin
         w_st_u    = bus.in_data[7];
         w_st_sr   = bus.in_sop ? '0 : w_sr_base;
         w_st_p    = bus.in_sop ? '0 : w_p_base;
         w_st_rate = bus.in_sop ? bus.rate : r_rate;
         w_st_idx  = 3'd7;
         w_st_eopb = bus.in_eop;
      end
      w_st_x   = mask_x(w_st_rate, w_st_p);
      w_st_bit = code_bit(w_st_u, w_st_sr, w_st_x ? G1 : G2);
      w_st_eop = w_st_eopb & (w_st_idx == 3'd0) & !(w_st_x & mask_y(w_st_rate, w_st_p));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_byte      <= '0;
         r_idx       <= '0;
         r_sr        <= '0;
         r_p         <= '0;
         r_rate      <= '0;
         r_eop_byte  <= 1'b0;
         r_out_bit   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
      end else if (w_load) begin
         r_state     <= w_st_x ? EMIT_X : EMIT_Y;
         r_byte      <= bus.in_data;
         r_idx       <= w_st_idx;
         r_sr        <= w_st_sr;
         r_p         <= w_st_p;
         r_rate      <= w_st_rate;
         r_eop_byte  <= bus.in_eop;
         r_out_bit   <= w_st_bit;
         r_out_valid <= 1'b1;
         r_out_sop   <= bus.in_sop;
         r_out_eop   <= w_st_eop;
      end else if (w_adv && r_idx != 3'd0) begin
         r_state   <= w_st_x ? EMIT_X : EMIT_Y;
         r_idx     <= w_st_idx;
         r_sr      <= w_st_sr;
         r_p       <= w_st_p;
         r_out_bit <= w_st_bit;
         r_out_sop <= 1'b0;
         r_out_eop <= w_st_eop;
      end else if (w_adv) begin
         r_state     <= IDLE;
         r_sr        <= w_sr_adv;
         r_p         <= w_p_adv;
         r_out_bit   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
      end else if (r_state == EMIT_X && w_out_acc) begin
         r_state   <= EMIT_Y;
         r_out_bit <= code_bit(w_u_cur, r_sr, G2);
         r_out_sop <= 1'b0;
         r_out_eop <= r_eop_byte & (r_idx == 3'd0);
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_bit   = r_out_bit;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sop   = r_out_sop;
   assign bus.out_eop   = r_out_eop;

endmodule

// File: tb/tb_cc_punct_enc.sv
// Bench for cc_punct_enc: random bytes and back-pressure checked against a
// bit-serial reference of the K=7 code and the puncture patterns.
module tb_cc_punct_enc;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   cc_punct_enc_if bus();

   cc_punct_enc #(.G1(7'o171), .G2(7'o133)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Pattern tables: bit p set means that position emits X (MX) / Y (MY).
   localparam int         PLEN [4] = '{1, 2, 3, 5};
   localparam logic [4:0] MX   [4] = '{5'b00001, 5'b00001, 5'b00101, 5'b10101};
   localparam logic [4:0] MY   [4] = '{5'b00001, 5'b00011, 5'b00011, 5'b01011};

   int tests = 0;
   int fails = 0;

   logic [7:0] tx_bytes[$];
   logic exp_b[$], exp_s[$], exp_e[$];
   logic got_b[$], got_s[$], got_e[$];
   int   got_cyc[$], acc_cyc[$];
   int   stall_err;
   int   stall_cnt;
   bit   timed_out;

   function automatic void model(input logic [1:0] rt, input bit with_eop);
      int hist[$];
      int n = 0;
      int h[7];
      logic x, y;
      int p;
      exp_b.delete(); exp_s.delete(); exp_e.delete();
      foreach (tx_bytes[i]) begin
         for (int k = 7; k >= 0; k--) begin
            h[0] = int'(tx_bytes[i][k]);
            for (int j = 1; j <= 6; j++)
               h[j] = (hist.size() >= j) ? hist[hist.size() - j] : 0;
            x = logic'(h[0] ^ h[1] ^ h[2] ^ h[3] ^ h[6]);
            y = logic'(h[0] ^ h[2] ^ h[3] ^ h[5] ^ h[6]);
            p = n % PLEN[rt];
            if (MX[rt][p]) begin exp_b.push_back(x); exp_s.push_back(1'b0); exp_e.push_back(1'b0); end
            if (MY[rt][p]) begin exp_b.push_back(y); exp_s.push_back(1'b0); exp_e.push_back(1'b0); end
            hist.push_back(h[0]);
            n++;
         end
      end
      if (exp_b.size() > 0) begin
         exp_s[0] = 1'b1;
         exp_e[exp_b.size() - 1] = logic'(with_eop);
      end
   endfunction

   function automatic int diff_idx();
      int n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
      for (int i = 0; i < n; i++)
         if (got_b[i] !== exp_b[i] || got_s[i] !== exp_s[i] || got_e[i] !== exp_e[i]) return i;
      if (got_b.size() != exp_b.size()) return n;
      return -1;
   endfunction

   function automatic logic [15:0] packed_got();
      logic [15:0] g = '0;
      for (int i = 0; i < 16 && i < got_b.size(); i++) g[15 - i] = got_b[i];
      return g;
   endfunction

   // Streams tx_bytes as one block and collects accepted beats until the
   // model's beat count is reached or the cycle budget runs out.
   task automatic drive(input logic [1:0] rt, input int ready_pct, input int valid_pct,
                        input bit rate_change, input bit with_eop, input int max_cycles);
      int   bi = 0;
      bit   just_acc = 1'b1;
      bit   prev_stall = 1'b0;
      logic prev_bit = 1'b0, prev_s = 1'b0, prev_e = 1'b0;
      got_b.delete(); got_s.delete(); got_e.delete(); got_cyc.delete(); acc_cyc.delete();
      stall_err = 0;
      stall_cnt = 0;
      timed_out = 1'b1;
      for (int cyc = 0; cyc < max_cycles; cyc++) begin
         @(negedge clk);
         bus.out_ready = (int'($urandom_range(0, 99)) < ready_pct);
         if (bi >= tx_bytes.size()) begin
            bus.in_valid = 1'b0;
            bus.in_sop   = 1'b0;
            bus.in_eop   = 1'b0;
         end else begin
            if (just_acc || !bus.in_valid)
               bus.in_valid = (int'($urandom_range(0, 99)) < valid_pct);
            bus.in_data = tx_bytes[bi];
            bus.in_sop  = (bi == 0);
            bus.in_eop  = with_eop && (bi == tx_bytes.size() - 1);
            bus.rate    = (bi == 0 || !rate_change) ? rt : (rt ^ 2'b11);
         end
         #1;
         if (prev_stall) begin
            stall_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_bit !== prev_bit ||
                bus.out_sop !== prev_s || bus.out_eop !== prev_e) stall_err++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_bit = bus.out_bit; prev_s = bus.out_sop; prev_e = bus.out_eop;
         just_acc = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            got_b.push_back(bus.out_bit); got_s.push_back(bus.out_sop);
            got_e.push_back(bus.out_eop); got_cyc.push_back(cyc);
         end
         if (bus.in_valid && bus.in_ready) begin
            acc_cyc.push_back(cyc);
            bi++;
            just_acc = 1'b1;
         end
         if (bi >= tx_bytes.size() && got_b.size() >= exp_b.size()) begin
            timed_out = 1'b0;
            break;
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      bus.rate = 2'b00; bus.in_data = '0; bus.in_valid = 1'b0;
      bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.out_ready = 1'b1;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_bit !== 1'b0 || bus.out_sop !== 1'b0 || bus.out_eop !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: valid=%b bit=%b sop=%b eop=%b, required all 0",
                  bus.out_valid, bus.out_bit, bus.out_sop, bus.out_eop);
      end
      tests++;
      if (bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_byte_half();
      int d;
      tx_bytes = '{8'h80};
      model(2'b00, 1'b1);
      drive(2'b00, 100, 100, 1'b0, 1'b1, 200);
      tests++;
      if (timed_out) begin fails++; $display("FAIL t1_timeout: got %0d beats, required %0d", got_b.size(), exp_b.size()); end
      d = diff_idx();
      tests++;
      if (d >= 0) begin fails++; $display("FAIL t1_model: first difference at beat %0d (got %0d beats, required %0d)", d, got_b.size(), exp_b.size()); end
      tests++;
      if (got_b.size() != 16 || packed_got() !== 16'hEF1C) begin
         fails++; $display("FAIL t1_pattern: got %h (%0d beats), required efic=16'hEF1C over 16 beats", packed_got(), got_b.size());
      end
      tests++;
      if (got_cyc.size() == 0 || acc_cyc.size() == 0 || got_cyc[0] != acc_cyc[0] + 1) begin
         fails++; $display("FAIL t1_latency: first out beat not one cycle after byte accept");
      end
   endtask

   task automatic test_three_quarter();
      logic [10:0] g = '0;
      tx_bytes = '{8'h80};
      model(2'b10, 1'b1);
      drive(2'b10, 100, 100, 1'b0, 1'b1, 200);
      for (int i = 0; i < 11 && i < got_b.size(); i++) g[10 - i] = got_b[i];
      tests++;
      if (timed_out || got_b.size() != 11 || g !== 11'b11011100110) begin
         fails++; $display("FAIL t2_pattern: got %b (%0d beats), required 11011100110 (11 beats)", g, got_b.size());
      end
      tests++;
      if (diff_idx() >= 0) begin fails++; $display("FAIL t2_flags: first difference at beat %0d", diff_idx()); end
   endtask

   task automatic test_back_to_back();
      bit gaps_ok = 1'b1;
      tx_bytes.delete();
      for (int i = 0; i < 4; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
      model(2'b00, 1'b1);
      drive(2'b00, 100, 100, 1'b0, 1'b1, 400);
      tests++;
      if (timed_out || diff_idx() >= 0) begin
         fails++; $display("FAIL t3_model: got %0d beats, first difference %0d, required %0d beats", got_b.size(), diff_idx(), exp_b.size());
      end
      tests++;
      if (got_cyc.size() != 64 || got_cyc[63] - got_cyc[0] != 63) begin
         fails++; $display("FAIL t3_contiguous: got %0d beats, not 64 contiguous cycles", got_cyc.size());
      end
      for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i - 1] != 16) gaps_ok = 1'b0;
      tests++;
      if (acc_cyc.size() != 4 || !gaps_ok) begin
         fails++; $display("FAIL t3_in_ready: got %0d accepts (spacing ok=%0b), required 4 spaced 16 cycles", acc_cyc.size(), gaps_ok);
      end
   endtask

   task automatic test_backpressure();
      tx_bytes = '{8'h80};
      model(2'b00, 1'b1);
      drive(2'b00, 50, 100, 1'b0, 1'b1, 400);
      tests++;
      if (timed_out || diff_idx() >= 0 || packed_got() !== 16'hEF1C) begin
         fails++; $display("FAIL t4_sequence: got %h (%0d beats), required 16'hEF1C", packed_got(), got_b.size());
      end
      tests++;
      if (stall_err != 0) begin
         fails++; $display("FAIL t4_stall_hold: %0d of %0d stalled cycles changed outputs, required 0", stall_err, stall_cnt);
      end
   endtask

   task automatic test_rate_latch();
      tx_bytes.delete();
      for (int i = 0; i < 3; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
      model(2'b11, 1'b1);
      drive(2'b11, 100, 100, 1'b1, 1'b1, 300);
      tests++;
      if (timed_out || got_b.size() != 29) begin
         fails++; $display("FAIL t5_count: got %0d beats, required 29", got_b.size());
      end
      tests++;
      if (diff_idx() >= 0) begin fails++; $display("FAIL t5_model: first difference at beat %0d", diff_idx()); end
   endtask

   task automatic test_reset_mid_block();
      tx_bytes.delete();
      for (int i = 0; i < 4; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
      model(2'b00, 1'b1);
      drive(2'b00, 100, 100, 1'b0, 1'b1, 20);
      reset_n = 1'b0;
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_bit !== 1'b0 || bus.out_sop !== 1'b0 ||
          bus.out_eop !== 1'b0 || bus.in_ready !== 1'b1) begin
         fails++; $display("FAIL t6_reset_outputs: valid=%b bit=%b sop=%b eop=%b ready=%b, required 0 0 0 0 1",
                           bus.out_valid, bus.out_bit, bus.out_sop, bus.out_eop, bus.in_ready);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      tx_bytes = '{8'h80};
      model(2'b00, 1'b1);
      drive(2'b00, 100, 100, 1'b0, 1'b1, 200);
      tests++;
      if (timed_out || diff_idx() >= 0 || packed_got() !== 16'hEF1C) begin
         fails++; $display("FAIL t6_after_reset: got %h (%0d beats), required 16'hEF1C", packed_got(), got_b.size());
      end
   endtask

   task automatic test_random_blocks();
      logic [1:0] rt;
      bit         eop;
      for (int blk = 0; blk < 8; blk++) begin
         rt  = 2'($urandom_range(0, 3));
         eop = ($urandom_range(0, 3) != 0);
         tx_bytes.delete();
         for (int i = 0; i < int'($urandom_range(1, 5)); i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
         model(rt, eop);
         drive(rt, 60, 70, 1'b1, eop, 3000);
         tests++;
         if (timed_out || diff_idx() >= 0) begin
            fails++; $display("FAIL rand_blk%0d: rate=%b got %0d beats, first difference %0d, required %0d beats",
                              blk, rt, got_b.size(), diff_idx(), exp_b.size());
         end
         tests++;
         if (stall_err != 0) begin
            fails++; $display("FAIL rand_stall%0d: %0d stalled cycles changed outputs, required 0", blk, stall_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_byte_half();
      test_three_quarter();
      test_back_to_back();
      test_backpressure();
      test_rate_latch();
      test_reset_mid_block();
      test_random_blocks();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
